// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  // 3-bit operation codes sampled together with start
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADC  = 3'b010;
  localparam logic [2:0] OP_SBC  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_NOP0 = 3'b110;
  localparam logic [2:0] OP_NOP1 = 3'b111;

  // Control states: idle/accepting, or multiplier iterating
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

  // Persistent status flags
  typedef struct packed {
    logic c;  // carry (no-borrow for subtracts, unsigned overflow for MUL)
    logic z;  // result == 0
    logic n;  // result MSB
    logic v;  // signed overflow
  } flags_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier. load_i latches the operands and clears the
// accumulator; each following cycle adds the (left-shifting) multiplicand when
// the (right-shifting) multiplier LSB is set. last_o marks the cycle whose
// step is the final one, and product_o then carries the finished product.
module mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;

  // Load operands or perform one add-and-shift step per cycle
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (load_i) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = CNT_W'(WIDTH);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // The step that takes the counter from 1 to 0 completes the product
  always_comb begin
    last_o    = run_q && (cnt_q == CNT_W'(1));
    product_o = acc_d;
  end

  // Multiplier state registers; reset abandons any product in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered arithmetic unit with persistent flags, carry-chained ADC/SBC,
// compare, and a WIDTH-cycle shift-add multiplier.
// Optional build macro ALU_SAT_EN: saturate signed-overflowing add/sub results
// and clamp an overflowing MUL result to all-ones; otherwise results wrap.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  flags_t             flags_q, flags_d;
  logic               done_q, done_d;

  logic               sub_s;
  logic               cin_s;
  logic [WIDTH-1:0]   b_eff_s;
  logic [WIDTH:0]     sum_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   arith_res_s;

  logic               mul_load_s;
  logic               mul_last_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic               mul_hi_s;
  logic [WIDTH-1:0]   mul_res_s;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load_i    (mul_load_s),
    .a_i       (a),
    .b_i       (b),
    .last_o    (mul_last_s),
    .product_o (mul_prod_s)
  );

  // Adder datapath shared by ADD/SUB/ADC/SBC/CMP; carry-in uses the flag
  // as it stood before this edge, so chained ops see the previous result
  always_comb begin
    sub_s   = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    b_eff_s = sub_s ? ~b : b;
    case (op)
      OP_SUB, OP_CMP: cin_s = 1'b1;
      OP_ADC, OP_SBC: cin_s = flags_q.c;
      default:        cin_s = 1'b0;
    endcase
    sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    ovf_s = (a[MSB] == b_eff_s[MSB]) && (sum_s[MSB] != a[MSB]);
`ifdef ALU_SAT_EN
    if (ovf_s) begin
      arith_res_s = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      arith_res_s = sum_s[MSB:0];
    end
`else
    arith_res_s = sum_s[MSB:0];
`endif
  end

  // Multiplier result and its unsigned-overflow indication
  always_comb begin
    mul_hi_s = |mul_prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_SAT_EN
    if (mul_hi_s) begin
      mul_res_s = {WIDTH{1'b1}};
    end else begin
      mul_res_s = mul_prod_s[WIDTH-1:0];
    end
`else
    mul_res_s = mul_prod_s[WIDTH-1:0];
`endif
  end

  // Control FSM: issue/complete single-cycle ops, launch and retire MUL
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    flags_d    = flags_q;
    done_d     = 1'b0;
    mul_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              result_d  = arith_res_s;
              flags_d.c = sum_s[WIDTH];
              flags_d.v = ovf_s;
              flags_d.z = (arith_res_s == {WIDTH{1'b0}});
              flags_d.n = arith_res_s[MSB];
              done_d    = 1'b1;
            end
            OP_CMP: begin
              flags_d.c = sum_s[WIDTH];
              flags_d.v = ovf_s;
              flags_d.z = (sum_s[MSB:0] == {WIDTH{1'b0}});
              flags_d.n = sum_s[MSB];
              done_d    = 1'b1;
            end
            OP_MUL: begin
              mul_load_s = 1'b1;
              state_d    = ST_MUL_RUN;
            end
            OP_NOP0, OP_NOP1: begin
              done_d = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_RUN: begin
        if (mul_last_s) begin
          result_d  = mul_res_s;
          flags_d.c = mul_hi_s;
          flags_d.v = 1'b0;
          flags_d.z = (mul_res_s == {WIDTH{1'b0}});
          flags_d.n = mul_res_s[MSB];
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_MUL_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, result, flag and done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= {WIDTH{1'b0}};
      flags_q  <= '{c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    result   = result_q;
    carry    = flags_q.c;
    zero     = flags_q.z;
    negative = flags_q.n;
    overflow = flags_q.v;
    busy     = (state_q == ST_MUL_RUN);
    done     = done_q;
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed test-plan steps followed
// by randomized operations, all checked against an integer-arithmetic model.
module tb_seq_alu;

  localparam int W    = 8;
  localparam int MODV = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int MAXU = MODV - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         carry, zero, negative, overflow, busy, done;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_res;
  bit m_c, m_z, m_n, m_v;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit exp_busy, input bit exp_done);
    chk({tag, ".result"}, 32'(result), 32'(m_res));
    chk({tag, ".carry"}, 32'(carry), 32'(m_c));
    chk({tag, ".zero"}, 32'(zero), 32'(m_z));
    chk({tag, ".neg"}, 32'(negative), 32'(m_n));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_v));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  function automatic int to_signed(input int u);
    return (u >= HALF) ? u - MODV : u;
  endfunction

  // Behavioural model: plain integer arithmetic on operand values
  task automatic model_op(input int o, input int ua, input int ub);
    int ubp, cin, usum, ssum, r, prod;
    bit c, v, inv;
    if (o == 4) begin
      prod = ua * ub;
      c = (prod > MAXU);
      r = prod % MODV;
`ifdef ALU_SAT_EN
      if (c) r = MAXU;
`endif
      m_res = r; m_c = c; m_v = 1'b0; m_z = (r == 0); m_n = (r >= HALF);
    end else if (o <= 3 || o == 5) begin
      inv  = (o == 1 || o == 3 || o == 5);
      ubp  = inv ? (MAXU - ub) : ub;
      cin  = (o == 0) ? 0 : ((o == 1 || o == 5) ? 1 : int'(m_c));
      usum = ua + ubp + cin;
      c    = (usum > MAXU);
      r    = usum % MODV;
      ssum = to_signed(ua) + to_signed(ubp) + cin;
      v    = (ssum > HALF - 1) || (ssum < -HALF);
      if (o == 5) begin
        m_c = c; m_v = v; m_z = (r == 0); m_n = (r >= HALF);
      end else begin
`ifdef ALU_SAT_EN
        if (v) r = (ua < HALF) ? HALF - 1 : HALF;
`endif
        m_res = r; m_c = c; m_v = v; m_z = (r == 0); m_n = (r >= HALF);
      end
    end
    // opcodes 6/7: nothing changes
  endtask

  task automatic model_reset();
    m_res = 0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  // Issue one op at the next edge; MUL runs to completion with junk inputs
  // (including stray start pulses) driven while busy.
  task automatic run_op(input int o, input int x, input int y, input string tag);
    op = 3'(o); a = W'(x); b = W'(y); start = 1'b1;
    @(posedge clk); #1;
    if (o != 4) begin
      model_op(o, x, y);
      check_all(tag, 1'b0, 1'b1);
    end else begin
      check_all({tag, ".load"}, 1'b1, 1'b0);
      for (int i = 1; i < W; i++) begin
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom_range(0, 7));
        a     = W'($urandom);
        b     = W'($urandom);
        @(posedge clk); #1;
        check_all({tag, ".run"}, 1'b1, 1'b0);
      end
      @(posedge clk); #1;
      model_op(o, x, y);
      check_all({tag, ".done"}, 1'b0, 1'b1);
      start = 1'b0;
    end
  endtask

  task automatic idle_cycle(input string tag);
    start = 1'b0;
    @(posedge clk); #1;
    check_all(tag, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // directed test-plan steps (back-to-back issue)
    run_op(0, 8'h01, 8'h02, "add1");
    chk("tp.add1", 32'(result), 32'h03);
    run_op(1, 8'h8A, 8'h05, "sub1");
    chk("tp.sub1", 32'(result), 32'h85);
    chk("tp.sub1.c", 32'(carry), 32'h1);
    idle_cycle("idle1");
    run_op(0, 8'hFF, 8'h01, "add_wrap");
    chk("tp.add_wrap.z", 32'(zero), 32'h1);
    run_op(2, 8'h00, 8'h00, "adc");
    chk("tp.adc", 32'(result), 32'h01);
    run_op(3, 8'h05, 8'h05, "sbc");
    chk("tp.sbc", 32'(result), 32'hFF);
    chk("tp.sbc.c", 32'(carry), 32'h0);
    run_op(0, 8'h7F, 8'h01, "add_ovf");
`ifdef ALU_SAT_EN
    chk("tp.add_ovf", 32'(result), 32'h7F);
`else
    chk("tp.add_ovf", 32'(result), 32'h80);
`endif
    chk("tp.add_ovf.v", 32'(overflow), 32'h1);
    run_op(5, 8'h10, 8'h10, "cmp");
    chk("tp.cmp.z", 32'(zero), 32'h1);
    run_op(6, 8'h33, 8'h44, "nop");
    idle_cycle("idle2");

    run_op(4, 8'h0C, 8'h0B, "mul1");
    chk("tp.mul1", 32'(result), 32'h84);
    idle_cycle("mul1.nodone");
    run_op(4, 8'h20, 8'h10, "mul2");
`ifdef ALU_SAT_EN
    chk("tp.mul2", 32'(result), 32'hFF);
`else
    chk("tp.mul2", 32'(result), 32'h00);
`endif
    chk("tp.mul2.c", 32'(carry), 32'h1);
    run_op(5, 8'h01, 8'h02, "cmp_after_done");  // issued in the done cycle

    // reset in the middle of a MUL
    op = 3'd4; a = 8'h0F; b = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_all("rstmul.load", 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check_all("rstmul.run", 1'b1, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all("rstmul.reset", 1'b0, 1'b0);
    for (int i = 0; i < W + 2; i++) idle_cycle("rstmul.quiet");
    run_op(0, 8'h02, 8'h03, "add_after_rst");
    chk("tp.add_after_rst", 32'(result), 32'h05);
    idle_cycle("idle3");

    // randomized operations, sometimes back-to-back, sometimes with gaps
    for (int n = 0; n < 150; n++) begin
      int ro, ra, rb;
      ro = $urandom_range(0, 7);
      ra = $urandom_range(0, MAXU);
      rb = $urandom_range(0, MAXU);
      if (n % 10 == 0) ra = (n % 20 == 0) ? MAXU : HALF;
      run_op(ro, ra, rb, "rand");
      if ($urandom_range(0, 2) == 0) idle_cycle("rand.idle");
    end
    idle_cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised successor to the SAP-1 combinational adder/subtracter.
- Registered arithmetic unit with a persistent carry/flag register, carry-chained ops (ADC/SBC), a compare op and an iterative shift-add multiplier.
- Sits between the A/B registers and the bus; the controller drives `start`/`op` and waits for `done`.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  operation code, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- result  out  WIDTH  registered result
- carry  out  1  carry flag (registered, persistent)
- zero  out  1  zero flag
- negative  out  1  result MSB
- overflow  out  1  signed-overflow flag
- busy  out  1  high while a MUL iterates
- done  out  1  one-cycle completion pulse

Behaviour:
- Single clock `clk`; synchronous active-high reset `rst`.
- Reset:
  - result=0, carry=zero=negative=overflow=0, busy=0, done=0, state=IDLE.
  - Applies at any time; aborts an in-flight MUL with no done pulse.
- op encoding:
  - 000 ADD: a+b
  - 001 SUB: a+~b+1
  - 010 ADC: a+b+carry
  - 011 SBC: a+~b+carry
  - 100 MUL
  - 101 CMP: SUB, flags only, result unchanged
  - 110/111 NOP: result and flags unchanged, done still pulses
- Arithmetic width rules:
  - Add/sub use a WIDTH+1-bit sum; carry=sum[WIDTH].
  - SUB/SBC carry=1 means no borrow.
  - overflow=(a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is b or ~b.
  - zero=(result==0); negative=result[MSB].
  - Flags update only on completion; otherwise they hold.
- State machine: IDLE, MUL_RUN.
  - IDLE + start + op≠MUL:
    - result/flags registered at that edge; done=1 for the next cycle.
    - Latency 1; back-to-back issue every cycle is allowed.
  - IDLE + start + op=MUL:
    - Latch a, b into internal registers; clear the 2·WIDTH accumulator; counter=WIDTH.
    - busy=1; go to MUL_RUN.
  - MUL_RUN, each cycle: if multiplier LSB set, add multiplicand to the accumulator; shift; decrement counter.
  - MUL_RUN, counter reaches 0:
    - result=acc[WIDTH-1:0]; carry=|acc[2W-1:W] (unsigned overflow).
    - overflow=0; zero/negative computed from result.
    - busy=0; done pulses; return to IDLE.
  - MUL total: done asserted WIDTH+1 cycles after the start edge.
- Handshake and boundaries:
  - start while busy=1 is ignored entirely; no queueing.
  - done and busy are never both high.
  - start in the cycle done is high is accepted, since the state is IDLE.
  - a/b/op changes while busy have no effect; operands are latched.
  - The carry-in for ADC/SBC is the carry flag as registered before the start edge.

Optional Feature:
- ALU_SAT_EN
- Defined:
  - ADD/SUB/ADC/SBC with overflow=1 clamp result to the signed max (0111…1) if a[MSB]=0, else the signed min (100…0).
  - overflow still reads 1; carry is unchanged from the unsaturated sum.
  - MUL: if carry=1, result clamps to all-ones.
- Undefined: results wrap modulo 2^WIDTH.

Decomposition:
- Package alu_pkg:
  - localparams OP_ADD..OP_NOP1 (3-bit)
  - state encoding ST_IDLE/ST_MUL_RUN
  - a flags struct/width constant
- One sub-module, mul_shift_add: iterative multiplier (load, step, count, finish), WIDTH-parametrised; seq_alu owns the flags and handshake.

Test Plan:
- WIDTH=8. ADD a=0x01 b=0x02 -> next cycle result=0x03, C=0 Z=0 N=0 V=0, done pulse 1 cycle. Then SUB a=0x8A b=0x05 -> 0x85, C=1 N=1 V=0.
- ADD 0xFF+0x01 -> 0x00, C=1 Z=1. Next ADC 0x00+0x00 -> 0x01, C=0. Then SBC 0x05-0x05 with C=0 -> 0xFF, C=0 N=1.
- ADD 0x7F+0x01 -> 0x80, V=1 N=1; with ALU_SAT_EN -> 0x7F, V=1. CMP 0x10,0x10 -> result unchanged, Z=1 C=1.
- MUL 0x0C×0x0B -> busy 8 cycles, done at start+9, result=0x84 C=0. Extra start pulses with op=ADD during busy are ignored, with no extra done.
- MUL 0x20×0x10 -> result=0x00, C=1 Z=1. With ALU_SAT_EN -> 0xFF, C=1.
- Assert rst at MUL cycle 4 -> next cycle all outputs 0, busy=0, no done. Following ADD 0x02+0x03 -> 0x05 after 1 cycle.
